// File: rtl/pulse_counter_multich_pkg.sv
// Shared types and default parameter values for the multichannel pulse counter.
package pulse_counter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2
    } ser_state_e;

    localparam int DEF_N_CH        = 4;
    localparam int DEF_CNT_W       = 8;
    localparam int DEF_RTC_DIV     = 1;
    localparam int DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/pulse_counter_multich_if.sv
// Serial snapshot stream and status flags leaving the pulse counter.
import pulse_counter_pkg::*;

interface pulse_counter_multich_if #(
    parameter int N_CH = DEF_N_CH
) ();

    logic                    serial_out;
    logic                    sl_out;
    logic [$clog2(N_CH)-1:0] ch_addr_out;
    logic                    ovf_ch_out;
    logic                    ovf_global;
    logic                    ovf_rtc_out;

    modport master (
        output serial_out,
        output sl_out,
        output ch_addr_out,
        output ovf_ch_out,
        output ovf_global,
        output ovf_rtc_out
    );

    modport slave (
        input serial_out,
        input sl_out,
        input ch_addr_out,
        input ovf_ch_out,
        input ovf_global,
        input ovf_rtc_out
    );

endinterface

// File: rtl/pulse_counter_multich_channel.sv
// One input channel: synchroniser, registered rising-edge detector, wrapping
// counter with sticky overflow, and the snapshot register read by the serialiser.
module pc_channel
    import pulse_counter_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ch_in,
    input  logic             win_end,
    input  logic             snap_en,
    output logic [CNT_W-1:0] snap_cnt,
    output logic             snap_ovf,
    output logic             ovf_live
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   dly_q, dly_d;
    logic                   pulse_q, pulse_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   ovf_q, ovf_d;
    logic [CNT_W-1:0]       snap_cnt_q, snap_cnt_d;
    logic                   snap_ovf_q, snap_ovf_d;

    // A pulse landing in the window-end cycle is the first count of the new window.
    always_comb begin
        sync_d     = {sync_q[SYNC_STAGES-2:0], ch_in};
        dly_d      = sync_q[SYNC_STAGES-1];
        pulse_d    = sync_q[SYNC_STAGES-1] & ~dly_q;
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        if (win_end) begin
            cnt_d = pulse_q ? CNT_W'(1) : '0;
            ovf_d = 1'b0;
        end else if (pulse_q) begin
            cnt_d = cnt_q + 1'b1;
            if (&cnt_q) begin
                ovf_d = 1'b1;
            end
        end
        snap_cnt_d = snap_en ? cnt_q : snap_cnt_q;
        snap_ovf_d = snap_en ? ovf_q : snap_ovf_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q     <= '0;
            dly_q      <= 1'b0;
            pulse_q    <= 1'b0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            snap_cnt_q <= '0;
            snap_ovf_q <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            dly_q      <= dly_d;
            pulse_q    <= pulse_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            snap_cnt_q <= snap_cnt_d;
            snap_ovf_q <= snap_ovf_d;
        end
    end

    assign snap_cnt = snap_cnt_q;
    assign snap_ovf = snap_ovf_q;
    assign ovf_live = ovf_q;

endmodule

// File: rtl/pulse_counter_multich.sv
// Multichannel pulse counter: RTC-defined measurement windows, per-channel
// snapshot at each window end, and a serial stream of the snapshot words.
module pulse_counter_multich
    import pulse_counter_pkg::*;
#(
    parameter int N_CH        = DEF_N_CH,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int RTC_DIV     = DEF_RTC_DIV,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_CH-1:0]         ch_in,
    input  logic                    rtc,
    pulse_counter_multich_if.master out_if
);

    localparam int         CH_W       = $clog2(N_CH);
    localparam int         BIT_W      = $clog2(CNT_W);
    localparam logic [7:0] PRESC_LAST = 8'(RTC_DIV - 1);

    logic [SYNC_STAGES-1:0] rtc_sync_q, rtc_sync_d;
    logic                   rtc_dly_q, rtc_dly_d;
    logic                   rtc_pulse_q, rtc_pulse_d;
    logic [7:0]             presc_q, presc_d;
    ser_state_e             state_q, state_d;
    logic [CH_W-1:0]        ch_q, ch_d;
    logic [BIT_W-1:0]       bit_q, bit_d;
    logic [CH_W-1:0]        addr_q, addr_d;
    logic                   serial_q, serial_d;
    logic                   sl_q, sl_d;
    logic                   ovf_ch_q, ovf_ch_d;
    logic                   ovf_global_q, ovf_global_d;
    logic                   ovf_rtc_q, ovf_rtc_d;
    logic                   win_end, snap_en;
    logic [CNT_W-1:0]       snap_cnt [N_CH];
    logic [N_CH-1:0]        snap_ovf, ovf_live;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        pc_channel #(
            .CNT_W       (CNT_W),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_ch (
            .clk      (clk),
            .reset    (reset),
            .ch_in    (ch_in[i]),
            .win_end  (win_end),
            .snap_en  (snap_en),
            .snap_cnt (snap_cnt[i]),
            .snap_ovf (snap_ovf[i]),
            .ovf_live (ovf_live[i])
        );
    end

    // Window ends are always honoured by the counters; only the snapshot is
    // dropped when a frame is still being sent.
    always_comb begin
        rtc_sync_d   = {rtc_sync_q[SYNC_STAGES-2:0], rtc};
        rtc_dly_d    = rtc_sync_q[SYNC_STAGES-1];
        rtc_pulse_d  = rtc_sync_q[SYNC_STAGES-1] & ~rtc_dly_q;
        win_end      = rtc_pulse_q && (presc_q == PRESC_LAST);
        snap_en      = win_end && (state_q == IDLE);
        presc_d      = presc_q;
        if (win_end) begin
            presc_d = '0;
        end else if (rtc_pulse_q) begin
            presc_d = presc_q + 1'b1;
        end
        ovf_rtc_d    = ovf_rtc_q;
        if (win_end) begin
            ovf_rtc_d = (state_q != IDLE);
        end
        ovf_global_d = snap_en ? |ovf_live : ovf_global_q;
    end

    always_comb begin
        state_d  = state_q;
        ch_d     = ch_q;
        bit_d    = bit_q;
        sl_d     = 1'b0;
        serial_d = 1'b0;
        addr_d   = '0;
        ovf_ch_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (win_end) begin
                    state_d = LOAD;
                    ch_d    = '0;
                end
            end
            LOAD: begin
                sl_d     = 1'b1;
                addr_d   = ch_q;
                ovf_ch_d = snap_ovf[ch_q];
                bit_d    = BIT_W'(CNT_W - 1);
                state_d  = SHIFT;
            end
            SHIFT: begin
                serial_d = snap_cnt[ch_q][bit_q];
                addr_d   = ch_q;
                ovf_ch_d = snap_ovf[ch_q];
                if (bit_q == '0) begin
                    if (ch_q == CH_W'(N_CH - 1)) begin
                        state_d = IDLE;
                        ch_d    = '0;
                    end else begin
                        state_d = LOAD;
                        ch_d    = ch_q + 1'b1;
                    end
                end else begin
                    bit_d = bit_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rtc_sync_q   <= '0;
            rtc_dly_q    <= 1'b0;
            rtc_pulse_q  <= 1'b0;
            presc_q      <= '0;
            state_q      <= IDLE;
            ch_q         <= '0;
            bit_q        <= '0;
            addr_q       <= '0;
            serial_q     <= 1'b0;
            sl_q         <= 1'b0;
            ovf_ch_q     <= 1'b0;
            ovf_global_q <= 1'b0;
            ovf_rtc_q    <= 1'b0;
        end else begin
            rtc_sync_q   <= rtc_sync_d;
            rtc_dly_q    <= rtc_dly_d;
            rtc_pulse_q  <= rtc_pulse_d;
            presc_q      <= presc_d;
            state_q      <= state_d;
            ch_q         <= ch_d;
            bit_q        <= bit_d;
            addr_q       <= addr_d;
            serial_q     <= serial_d;
            sl_q         <= sl_d;
            ovf_ch_q     <= ovf_ch_d;
            ovf_global_q <= ovf_global_d;
            ovf_rtc_q    <= ovf_rtc_d;
        end
    end

    assign out_if.serial_out  = serial_q;
    assign out_if.sl_out      = sl_q;
    assign out_if.ch_addr_out = addr_q;
    assign out_if.ovf_ch_out  = ovf_ch_q;
    assign out_if.ovf_global  = ovf_global_q;
    assign out_if.ovf_rtc_out = ovf_rtc_q;

endmodule

// File: tb/tb_pulse_counter_multich.sv
// Randomised bench for pulse_counter_multich: a window-level model predicts each
// frame's words, flags and strobe timing; a monitor decodes the serial streams.
module tb_pulse_counter_multich;
    import pulse_counter_pkg::*;

    localparam int N_CH  = 4;
    localparam int CNT_W = 8;
    localparam int SYNC  = 2;
    localparam int FRAME = N_CH * (CNT_W + 1);
    localparam int MODV  = 1 << CNT_W;

    logic            clk = 1'b0;
    logic            reset;
    logic [N_CH-1:0] ch_in;
    logic            rtc;
    logic            rtc3;

    always #5 clk = ~clk;

    pulse_counter_multich_if #(.N_CH(N_CH)) if1 ();
    pulse_counter_multich_if #(.N_CH(N_CH)) if3 ();

    pulse_counter_multich #(
        .N_CH(N_CH), .CNT_W(CNT_W), .RTC_DIV(1), .SYNC_STAGES(SYNC)
    ) dut1 (
        .clk(clk), .reset(reset), .ch_in(ch_in), .rtc(rtc), .out_if(if1.master)
    );

    pulse_counter_multich #(
        .N_CH(N_CH), .CNT_W(CNT_W), .RTC_DIV(3), .SYNC_STAGES(SYNC)
    ) dut3 (
        .clk(clk), .reset(reset), .ch_in(ch_in), .rtc(rtc3), .out_if(if3.master)
    );

    typedef struct {
        int dut;
        int addr;
        int word;
        int ovf;
        int glob;
        int cyc;
    } word_t;

    word_t exp_q[$];
    word_t obs_q[$];

    int n_compared   = 0;
    int n_mismatched = 0;
    int cyc          = 0;

    int win_cnt [2][N_CH];
    int rtc_edges [2];
    int last_snap [2];
    int ovf_rtc_exp [2];
    int div_of [2] = '{1, 3};
    int stim [N_CH];

    int in_word [2];
    int nbits [2];
    int val [2];
    int w_addr [2];
    int w_ovf [2];
    int w_glob [2];
    int w_cyc [2];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_compared++;
        if (observed !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: observed %0d, expected %0d (cycle %0d)", tag, observed, expected, cyc);
        end
    endtask

    // Decode both serial streams into words; address and flag must hold across a word.
    always @(negedge clk) begin
        logic [1:0] sl, ser, ovf, glob;
        int         addr [2];
        word_t      w;
        sl      = {if3.sl_out, if1.sl_out};
        ser     = {if3.serial_out, if1.serial_out};
        ovf     = {if3.ovf_ch_out, if1.ovf_ch_out};
        glob    = {if3.ovf_global, if1.ovf_global};
        addr[0] = int'(if1.ch_addr_out);
        addr[1] = int'(if3.ch_addr_out);
        for (int d = 0; d < 2; d++) begin
            if (reset) begin
                in_word[d] = 0;
            end else if (sl[d]) begin
                in_word[d] = 1;
                nbits[d]   = 0;
                val[d]     = 0;
                w_addr[d]  = addr[d];
                w_ovf[d]   = int'(ovf[d]);
                w_glob[d]  = int'(glob[d]);
                w_cyc[d]   = cyc;
            end else if (in_word[d] != 0) begin
                checkOutput("ovf_ch_hold", ovf[d], w_ovf[d]);
                checkOutput("addr_hold", addr[d], w_addr[d]);
                val[d] = val[d] * 2 + int'(ser[d]);
                nbits[d]++;
                if (nbits[d] == CNT_W) begin
                    w.dut  = d;
                    w.addr = w_addr[d];
                    w.word = val[d];
                    w.ovf  = w_ovf[d];
                    w.glob = w_glob[d];
                    w.cyc  = w_cyc[d];
                    obs_q.push_back(w);
                    in_word[d] = 0;
                end
            end
        end
    end

    task automatic clear_model();
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < N_CH; c++) win_cnt[d][c] = 0;
            rtc_edges[d]   = 0;
            last_snap[d]   = -100000;
            ovf_rtc_exp[d] = 0;
        end
    endtask

    task automatic set_stim(input int a, input int b, input int c, input int e);
        stim[0] = a;
        stim[1] = b;
        stim[2] = c;
        stim[3] = e;
    endtask

    // Pulses of 2 cycles high / 2 cycles low on all channels in parallel.
    task automatic applyStimulus();
        int mx = 0;
        for (int c = 0; c < N_CH; c++) begin
            if (stim[c] > mx) mx = stim[c];
            win_cnt[0][c] += stim[c];
            win_cnt[1][c] += stim[c];
        end
        for (int k = 0; k < mx; k++) begin
            for (int c = 0; c < N_CH; c++) ch_in[c] = (k < stim[c]);
            repeat (2) @(negedge clk);
            ch_in = '0;
            repeat (2) @(negedge clk);
        end
        repeat (2) @(negedge clk);
    endtask

    // One rtc edge for dut index d; mask channels rise in the very same cycle.
    task automatic rtc_pulse(input int d, input logic [N_CH-1:0] mask);
        int    we;
        int    any;
        word_t w;
        if (d == 0) rtc = 1'b1; else rtc3 = 1'b1;
        ch_in = mask;
        rtc_edges[d]++;
        if (rtc_edges[d] == div_of[d]) begin
            rtc_edges[d] = 0;
            we = cyc + SYNC + 2;
            if (we >= last_snap[d] + FRAME) begin
                any = 0;
                for (int c = 0; c < N_CH; c++) if (win_cnt[d][c] >= MODV) any = 1;
                for (int c = 0; c < N_CH; c++) begin
                    w.dut  = d;
                    w.addr = c;
                    w.word = win_cnt[d][c] % MODV;
                    w.ovf  = (win_cnt[d][c] >= MODV) ? 1 : 0;
                    w.glob = any;
                    w.cyc  = we + 1 + c * (CNT_W + 1);
                    exp_q.push_back(w);
                end
                last_snap[d]   = we;
                ovf_rtc_exp[d] = 0;
            end else begin
                ovf_rtc_exp[d] = 1;
            end
            for (int c = 0; c < N_CH; c++) win_cnt[d][c] = 0;
        end
        for (int c = 0; c < N_CH; c++) begin
            win_cnt[0][c] += int'(mask[c]);
            win_cnt[1][c] += int'(mask[c]);
        end
        repeat (2) @(negedge clk);
        rtc   = 1'b0;
        rtc3  = 1'b0;
        ch_in = '0;
        repeat (2) @(negedge clk);
    endtask

    task automatic expect_words(input string tag, input int d);
        int    waited = 0;
        word_t e, o;
        while (obs_q.size() < exp_q.size() && waited < 3000) begin
            @(negedge clk);
            waited++;
        end
        repeat (60) @(negedge clk);
        checkOutput({tag, "_nwords"}, obs_q.size(), exp_q.size());
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checkOutput({tag, "_dut"}, o.dut, e.dut);
            checkOutput({tag, "_addr"}, o.addr, e.addr);
            checkOutput({tag, "_word"}, o.word, e.word);
            checkOutput({tag, "_ovf_ch"}, o.ovf, e.ovf);
            checkOutput({tag, "_ovf_global"}, o.glob, e.glob);
            checkOutput({tag, "_sl_cycle"}, o.cyc, e.cyc);
        end
        exp_q.delete();
        obs_q.delete();
        checkOutput({tag, "_ovf_rtc"}, (d == 0) ? if1.ovf_rtc_out : if3.ovf_rtc_out, ovf_rtc_exp[d]);
    endtask

    initial begin
        int waited;
        reset = 1'b1;
        ch_in = '0;
        rtc   = 1'b0;
        rtc3  = 1'b0;
        clear_model();
        repeat (2) @(negedge clk);
        checkOutput("rst_serial_out", if1.serial_out, 0);
        checkOutput("rst_sl_out", if1.sl_out, 0);
        checkOutput("rst_ch_addr", if1.ch_addr_out, 0);
        checkOutput("rst_ovf_ch", if1.ovf_ch_out, 0);
        checkOutput("rst_ovf_global", if1.ovf_global, 0);
        checkOutput("rst_ovf_rtc", if1.ovf_rtc_out, 0);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        set_stim(5, 3, 0, 255);
        applyStimulus();
        rtc_pulse(0, '0);
        expect_words("basic", 0);

        set_stim($urandom_range(0, 20), $urandom_range(0, 20), 257, $urandom_range(0, 20));
        applyStimulus();
        rtc_pulse(0, '0);
        expect_words("wrap257", 0);
        set_stim(0, 0, 4, 0);
        applyStimulus();
        rtc_pulse(0, '0);
        expect_words("ovf_cleared", 0);

        for (int i = 0; i < 5; i++) begin
            set_stim($urandom_range(0, 300), $urandom_range(0, 300),
                     $urandom_range(0, 300), $urandom_range(0, 300));
            applyStimulus();
            rtc_pulse(0, '0);
            expect_words("random", 0);
        end

        set_stim(9, 17, 2, 40);
        applyStimulus();
        rtc_pulse(0, '0);
        repeat (6) @(negedge clk);
        rtc_pulse(0, '0);
        set_stim(1, 2, 3, 4);
        applyStimulus();
        expect_words("busy_drop", 0);
        set_stim(6, 0, 11, 1);
        applyStimulus();
        rtc_pulse(0, '0);
        expect_words("busy_recover", 0);

        set_stim(0, 2, 0, 0);
        applyStimulus();
        rtc_pulse(0, 4'b0010);
        expect_words("coincide_old", 0);
        set_stim(0, 3, 0, 0);
        applyStimulus();
        rtc_pulse(0, '0);
        expect_words("coincide_new", 0);

        set_stim(300, 7, 9, 2);
        applyStimulus();
        rtc_pulse(0, '0);
        set_stim(1, 1, 1, 1);
        applyStimulus();
        waited = 0;
        while (obs_q.size() < 1 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("mid_frame_ch0_seen", obs_q.size(), 1);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("mid_frame_rst_outputs",
                    {if1.serial_out, if1.sl_out, if1.ch_addr_out, if1.ovf_ch_out,
                     if1.ovf_global, if1.ovf_rtc_out}, 0);
        reset = 1'b0;
        clear_model();
        exp_q.delete();
        obs_q.delete();
        expect_words("post_rst_idle", 0);
        set_stim(2, 0, 1, 6);
        applyStimulus();
        rtc_pulse(0, '0);
        expect_words("post_rst_frame", 0);

        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        clear_model();
        exp_q.delete();
        obs_q.delete();
        @(negedge clk);
        set_stim(4, 0, 2, 1);
        applyStimulus();
        rtc_pulse(1, '0);
        expect_words("div3_edge1", 1);
        set_stim(1, 5, 0, 3);
        applyStimulus();
        rtc_pulse(1, '0);
        expect_words("div3_edge2", 1);
        set_stim(0, 1, 7, 2);
        applyStimulus();
        rtc_pulse(1, '0);
        expect_words("div3_edge3", 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

    initial begin
        #800000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/pulse_counter_multich.md
# pulse_counter_multich

Parametrised multichannel pulse counter, the next generation of the 4-channel design on the Tiny Tapeout tile. It counts rising edges on N_CH asynchronous inputs over a measurement window defined by RTC_DIV rising edges of an external RTC input. At each window end it snapshots all counts and per-channel overflow flags, then streams them out serially with a load strobe and channel address. It sits directly behind the tile wrapper, which maps its ports onto the dedicated I/O pins.

## Interface
- N_CH, default 4: number of input channels (2..8)
- CNT_W, default 8: counter width per channel (4..16)
- RTC_DIV, default 1: RTC rising edges per measurement window (1..255)
- SYNC_STAGES, default 2: synchroniser depth on ch_in and rtc (>=2)
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- ch_in  input  N_CH  asynchronous pulse inputs
- rtc  input  1  asynchronous real-time-clock tick input
- serial_out  output  1  snapshot data, MSB first
- sl_out  output  1  load strobe, high one cycle at the start of each channel word
- ch_addr_out  output  $clog2(N_CH)  channel index of the word being sent
- ovf_ch_out  output  1  overflow flag of the channel being sent
- ovf_global  output  1  OR of all snapshot overflow flags
- ovf_rtc_out  output  1  sticky: a window end was dropped because the serialiser was busy

## Operation
- Each ch_in bit and rtc pass through a SYNC_STAGES flop chain, then a rising-edge detector (compare with one further delayed flop).
- Per channel: on detected edge, count increments modulo 2^CNT_W; wrap from all-ones to 0 sets sticky ovf flag.
- RTC prescaler: counts rtc edges 0..RTC_DIV-1; the edge that completes RTC_DIV edges is a window end (wrap to 0).
- Window end, serialiser IDLE: snapshot every count and ovf flag into shadow registers; clear ovf_rtc_out; counts reset to 0 and ovf flags clear; serialiser starts.
- Window end, serialiser busy: snapshot dropped, counts and flags still reset, ovf_rtc_out set; current frame continues unchanged.
- Channel edge in the window-end cycle: counted in the new window (count becomes 1, ovf 0).
- Serialiser FSM: IDLE -> LOAD (ch = 0) -> SHIFT (CNT_W cycles) -> LOAD (ch+1) ... -> after SHIFT of ch N_CH-1 -> IDLE.
- LOAD: sl_out = 1, serial_out = 0, ch_addr_out = ch, ovf_ch_out = snapshot ovf[ch].
- SHIFT: sl_out = 0, serial_out = bit CNT_W-1 down to 0 of snapshot[ch]; ch_addr_out and ovf_ch_out held.
- IDLE: sl_out = 0, serial_out = 0, ch_addr_out = 0, ovf_ch_out = 0.
- ovf_global = OR of snapshot ovf flags, updated at snapshot, held until next snapshot.

## Timing
- All outputs registered; reset value of every output and internal register is 0, FSM IDLE, prescaler 0.
- Edge-to-count latency: SYNC_STAGES+1 clk cycles after the first clk edge sampling ch_in high.
- Input pulses need high and low phases each >= 2 clk periods; shorter pulses may be missed.
- Window end to first sl_out: 1 cycle after the snapshot cycle.
- Frame length: N_CH*(CNT_W+1) cycles; windows shorter than this set ovf_rtc_out.
- Reset asserted mid-frame: frame aborted immediately, all outputs 0; after deassertion the next complete RTC_DIV edges form the first window.

## Structure
- Package pulse_counter_pkg: serialiser state enum (IDLE, LOAD, SHIFT), default parameter constants.
- Sub-module pc_channel: synchroniser, edge detector, counter, ovf flag, snapshot register; instantiated N_CH times via generate.
- Top holds RTC synchroniser, prescaler and serialiser FSM.

## Test plan
- Defaults; 5 pulses ch0, 3 ch1, 0 ch2, 255 ch3, then one rtc edge -> words 5, 3, 0, 255 MSB first, sl_out at cycles 1, 10, 19, 28 after snapshot, ovf_global 0.
- 257 pulses on ch2 in one window -> word 1 on ch2, ovf_ch_out 1 during ch2 word only, ovf_global 1; next window with 4 pulses -> ovf_global 0.
- RTC_DIV = 3; rtc edges 1 and 2 produce no frame; edge 3 produces a frame.
- Second rtc edge 10 cycles after the first -> ovf_rtc_out 1, first frame completes with original values, third window (serialiser idle) clears ovf_rtc_out.
- Channel edge landing in window-end cycle -> excluded from snapshot, new window count 1.
- Reset asserted during SHIFT of ch1 -> all outputs 0 next cycle, FSM IDLE, counts 0.
